// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
// Shared definitions for the Viterbi encoder/puncture/decoder chain:
//   - speed encodings (SPEED_R12 = bypass, SPEED_PUNCT = apply pattern)
//   - the puncture FSM state type
//   - per-bit output valid encodings
//   - a small helper that counts the bits a keep mask deletes
// -----------------------------------------------------------------------------
package viterbi_pkg;

  localparam logic SPEED_R12   = 1'b0;
  localparam logic SPEED_PUNCT = 1'b1;

  localparam logic [1:0] VALID_NONE   = 2'b00;
  localparam logic [1:0] VALID_SINGLE = 2'b01;
  localparam logic [1:0] VALID_PAIR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } punct_state_e;

  // Number of encoder bits a 2-bit keep mask deletes (0..2).
  function automatic logic [1:0] deleted_bits(input logic [1:0] keep);
    return {1'b0, ~keep[0]} + {1'b0, ~keep[1]};
  endfunction

endpackage

// File: rtl/viterbi_punct_pattern.sv
// -----------------------------------------------------------------------------
// viterbi_punct_pattern
// Pattern index counter and keep-mask generator for the puncturing stage.
// The index advances once per accepted word, wraps after p_speed_size-1 and
// returns to 0 when a frame ends.
//
// Ports:
//   i_clk      clock
//   i_reset    asynchronous active-low reset
//   i_advance  an input word is accepted this cycle
//   i_restart  frame ends this cycle; next word starts at index 0
//   i_speed    effective speed for the current word (0 = keep all bits)
//   o_keep     {keep poly1 bit, keep poly0 bit} for the current word
// -----------------------------------------------------------------------------
module viterbi_punct_pattern
  import viterbi_pkg::*;
#(
  parameter int                      p_speed_size = 3,
  parameter logic [p_speed_size-1:0] p_speed_pol0 = 3'b101,
  parameter logic [p_speed_size-1:0] p_speed_pol1 = 3'b011
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_advance,
  input  logic       i_restart,
  input  logic       i_speed,
  output logic [1:0] o_keep
);

  localparam int IDX_W = (p_speed_size > 1) ? $clog2(p_speed_size) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(p_speed_size - 1);

  logic [IDX_W-1:0] idx_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      idx_q <= '0;
    end else if (i_restart) begin
      idx_q <= '0;
    end else if (i_advance) begin
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // NOTE: assigning a default before any condition keeps this block purely
  // combinational; a path that leaves o_keep unassigned would infer a latch.
  always_comb begin
    o_keep = 2'b11;
    if (i_speed == SPEED_PUNCT) begin
      o_keep = {p_speed_pol1[idx_q], p_speed_pol0[idx_q]};
    end
  end

endmodule

// File: rtl/viterbi_puncture.sv
// -----------------------------------------------------------------------------
// viterbi_puncture
// Puncturing stage between viterbi_enc and the modulator. Deletes encoder bits
// according to a per-position keep pattern and repacks the survivors into
// dense 2-bit words (stream order: data[0] before data[1]). Speed 0 bypasses
// the pattern (rate 1/2); speed 1 applies it (rate 3/4 with the defaults).
// Speed is latched on the first word of each frame.
//
// Ports:
//   i_clk       clock
//   i_reset     asynchronous active-low reset
//   i_data      encoder word, [0] = poly0 bit, [1] = poly1 bit
//   i_valid     i_data valid, accepted when o_ready = 1
//   i_last      final word of a frame (with i_valid)
//   i_speed     0 = bypass, 1 = puncture
//   o_ready     block accepts input this cycle (low only while flushing)
//   o_data      packed output, [0] = earlier bit
//   o_valid     2'b11 pair, 2'b01 single trailing bit, 2'b00 idle
//   o_last      final output word of a frame
//   o_drop_cnt  (only with VITERBI_PUNCT_CNT_EN) saturating count of deleted
//               bits since reset
//
// Optional feature macro: VITERBI_PUNCT_CNT_EN
// -----------------------------------------------------------------------------
module viterbi_puncture
  import viterbi_pkg::*;
#(
  parameter int                      p_speed_size = 3,
  parameter logic [p_speed_size-1:0] p_speed_pol0 = 3'b101,
  parameter logic [p_speed_size-1:0] p_speed_pol1 = 3'b011
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  input  logic        i_speed,
  output logic        o_ready,
  output logic [1:0]  o_data,
  output logic [1:0]  o_valid,
  output logic        o_last
`ifdef VITERBI_PUNCT_CNT_EN
  ,
  output logic [15:0] o_drop_cnt
`endif
);

  punct_state_e state_q, state_d;
  logic         speed_q;
  logic         eff_speed;
  logic         accept;
  logic [1:0]   keep;

  logic         hold_q, hold_d;
  logic         hold_bit_q, hold_bit_d;
  logic [1:0]   data_d;
  logic [1:0]   valid_d;
  logic         last_d;

  // Hold bit followed by survivors, packed from bit 0 upward.
  logic [2:0]   seq;
  logic [1:0]   cnt;

  assign o_ready   = (state_q != ST_FLUSH);
  assign accept    = i_valid && o_ready;
  // The first word of a frame uses the incoming speed, the rest the latched one.
  assign eff_speed = (state_q == ST_IDLE) ? i_speed : speed_q;

  viterbi_punct_pattern #(
    .p_speed_size (p_speed_size),
    .p_speed_pol0 (p_speed_pol0),
    .p_speed_pol1 (p_speed_pol1)
  ) u_pattern (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_advance (accept),
    .i_restart ((accept && i_last) || (state_q == ST_FLUSH)),
    .i_speed   (eff_speed),
    .o_keep    (keep)
  );

  always_comb begin
    seq = '0;
    cnt = '0;
    if (hold_q) begin
      seq[0] = hold_bit_q;
      cnt    = 2'd1;
    end
    if (keep[0]) begin
      seq[cnt] = i_data[0];
      cnt      = cnt + 2'd1;
    end
    if (keep[1]) begin
      seq[cnt] = i_data[1];
      cnt      = cnt + 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_bit_d = hold_bit_q;
    data_d     = '0;
    valid_d    = VALID_NONE;
    last_d     = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        data_d     = {1'b0, hold_bit_q};
        valid_d    = VALID_SINGLE;
        last_d     = 1'b1;
        hold_d     = 1'b0;
        hold_bit_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        if (accept) begin
          if (cnt >= 2'd2) begin
            data_d     = seq[1:0];
            valid_d    = VALID_PAIR;
            hold_d     = (cnt == 2'd3);
            hold_bit_d = seq[2];
          end else begin
            hold_d     = (cnt == 2'd1);
            hold_bit_d = seq[0];
          end
          state_d = ST_RUN;
          if (i_last) begin
            // A leftover bit needs its own output cycle; otherwise this word
            // (or an empty marker when everything was deleted) closes the frame.
            if (hold_d) begin
              state_d = ST_FLUSH;
            end else begin
              last_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      speed_q    <= SPEED_R12;
      hold_q     <= 1'b0;
      hold_bit_q <= 1'b0;
      o_data     <= '0;
      o_valid    <= VALID_NONE;
      o_last     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_bit_q <= hold_bit_d;
      o_data     <= data_d;
      o_valid    <= valid_d;
      o_last     <= last_d;
      if (accept && (state_q == ST_IDLE)) begin
        speed_q <= i_speed;
      end
    end
  end

`ifdef VITERBI_PUNCT_CNT_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, o_drop_cnt} + 17'(deleted_bits(keep));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_drop_cnt <= '0;
    end else if (accept) begin
      o_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_puncture.sv
// -----------------------------------------------------------------------------
// tb_viterbi_puncture
// Directed self-checking bench for viterbi_puncture with the default pattern
// (pol0 = 3'b101, pol1 = 3'b011, period 3). Each scenario drives a table of
// words, one per clock, and compares {o_ready, o_data, o_valid, o_last}
// one time unit after each rising edge against hand-derived values.
// Stimulus word encoding: {valid, last, speed, data[1:0]}.
// Expected encoding:      {o_ready, o_data[1:0], o_valid[1:0], o_last}.
// -----------------------------------------------------------------------------
module tb_viterbi_puncture;

  logic       i_clk;
  logic       i_reset;
  logic [1:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic       i_speed;
  logic       o_ready;
  logic [1:0] o_data;
  logic [1:0] o_valid;
  logic       o_last;
`ifdef VITERBI_PUNCT_CNT_EN
  logic [15:0] o_drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  viterbi_puncture dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_speed (i_speed),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_last  (o_last)
`ifdef VITERBI_PUNCT_CNT_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [5:0] observed();
    return {o_ready, o_data, o_valid, o_last};
  endfunction

  // Present one stimulus word for one clock, then settle just past the edge.
  task automatic step(input logic [4:0] s);
    i_valid = s[4];
    i_last  = s[3];
    i_speed = s[2];
    i_data  = s[1:0];
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_speed = 1'b0;
    i_data  = 2'b00;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (observed() !== 6'b1_00_00_0) begin
      failures++;
      $display("FAIL reset_state got=%b expected=%b", observed(), 6'b1_00_00_0);
    end
    i_reset = 1'b1;
    step(5'b0_0_0_00);
    checks++;
    if (observed() !== 6'b1_00_00_0) begin
      failures++;
      $display("FAIL reset_release got=%b expected=%b", observed(), 6'b1_00_00_0);
    end
  endtask

  task automatic test_bypass();
    logic [4:0] stim [4] = '{5'b1_0_0_01, 5'b1_0_0_10, 5'b1_1_0_11, 5'b0_0_0_00};
    logic [5:0] exp  [4] = '{6'b1_01_11_0, 6'b1_10_11_0, 6'b1_11_11_1, 6'b1_00_00_0};
    for (int i = 0; i < 4; i++) begin
      step(stim[i]);
      checks++;
      if (observed() !== exp[i]) begin
        failures++;
        $display("FAIL bypass[%0d] got=%b expected=%b", i, observed(), exp[i]);
      end
    end
  endtask

  task automatic test_rate34(input string tag);
    logic [4:0] stim [4] = '{5'b1_0_1_10, 5'b1_0_1_11, 5'b1_1_1_01, 5'b0_0_0_00};
    logic [5:0] exp  [4] = '{6'b1_10_11_0, 6'b1_00_00_0, 6'b1_11_11_1, 6'b1_00_00_0};
    for (int i = 0; i < 4; i++) begin
      step(stim[i]);
      checks++;
      if (observed() !== exp[i]) begin
        failures++;
        $display("FAIL %s[%0d] got=%b expected=%b", tag, i, observed(), exp[i]);
      end
    end
  endtask

  // Word 3 is offered during the flush cycle and must be held off; it is
  // accepted one cycle later as a single-word bypass frame.
  task automatic test_flush();
    logic [4:0] stim [5] = '{5'b1_0_1_10, 5'b1_1_1_11, 5'b1_1_0_11, 5'b1_1_0_11,
                             5'b0_0_0_00};
    logic [5:0] exp  [5] = '{6'b1_10_11_0, 6'b0_00_00_0, 6'b1_01_01_1, 6'b1_11_11_1,
                             6'b1_00_00_0};
    for (int i = 0; i < 5; i++) begin
      step(stim[i]);
      checks++;
      if (observed() !== exp[i]) begin
        failures++;
        $display("FAIL flush[%0d] got=%b expected=%b", i, observed(), exp[i]);
      end
    end
  endtask

  // Survivors per word: 2,1,1,2,1,1 -> pairs after words 0,2,3,5.
  task automatic test_wrap();
    logic [4:0] stim [7] = '{5'b1_0_1_11, 5'b1_0_1_11, 5'b1_0_1_11, 5'b1_0_1_11,
                             5'b1_0_1_11, 5'b1_1_1_11, 5'b0_0_0_00};
    logic [5:0] exp  [7] = '{6'b1_11_11_0, 6'b1_00_00_0, 6'b1_11_11_0, 6'b1_11_11_0,
                             6'b1_00_00_0, 6'b1_11_11_1, 6'b1_00_00_0};
    for (int i = 0; i < 7; i++) begin
      step(stim[i]);
      checks++;
      if (observed() !== exp[i]) begin
        failures++;
        $display("FAIL wrap[%0d] got=%b expected=%b", i, observed(), exp[i]);
      end
    end
  endtask

  // Frame A starts at speed 0 then raises i_speed (ignored); frame B starts at
  // speed 1 then lowers it (ignored).
  task automatic test_speed_latch();
    logic [4:0] stim [7] = '{5'b1_0_0_01, 5'b1_0_1_10, 5'b1_1_1_11,
                             5'b1_0_1_10, 5'b1_0_0_11, 5'b1_1_0_01, 5'b0_0_0_00};
    logic [5:0] exp  [7] = '{6'b1_01_11_0, 6'b1_10_11_0, 6'b1_11_11_1,
                             6'b1_10_11_0, 6'b1_00_00_0, 6'b1_11_11_1, 6'b1_00_00_0};
    for (int i = 0; i < 7; i++) begin
      step(stim[i]);
      checks++;
      if (observed() !== exp[i]) begin
        failures++;
        $display("FAIL speed_latch[%0d] got=%b expected=%b", i, observed(), exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    // Reset while a pair is on the output: it must clear without a clock edge.
    step(5'b1_0_1_10);
    checks++;
    if (observed() !== 6'b1_10_11_0) begin
      failures++;
      $display("FAIL midreset_pre got=%b expected=%b", observed(), 6'b1_10_11_0);
    end
    i_valid = 1'b0;
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if (observed() !== 6'b1_00_00_0) begin
      failures++;
      $display("FAIL midreset_async got=%b expected=%b", observed(), 6'b1_00_00_0);
    end
    #3 i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    // Second reset with the hold register full (after words at index 0 and 1).
    step(5'b1_0_1_10);
    step(5'b1_0_1_11);
    i_valid = 1'b0;
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if (observed() !== 6'b1_00_00_0) begin
      failures++;
      $display("FAIL midreset_hold got=%b expected=%b", observed(), 6'b1_00_00_0);
    end
    #3 i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    test_rate34("after_reset");
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_rate34("rate34");
    test_flush();
    test_wrap();
    test_speed_latch();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/viterbi_puncture.md
Name: viterbi_puncture

Overview:
Puncturing stage placed directly downstream of viterbi_enc and upstream of the channel/modulator. It deletes encoder output bits according to a per-position keep pattern and repacks the survivors into dense 2-bit words. A speed of 0 bypasses it at rate 1/2; with the default pattern, speed 1 gives rate 3/4. Its pattern and bit order mirror viterbi_speed_map, which re-inserts the erasures before viterbi_dec.

Parameters:
p_speed_size, 3, period of the puncture pattern in input words (≥1).
p_speed_pol0, 3'b101, keep mask for encoder bit 0 (polynomial 0); LSB is pattern position 0.
p_speed_pol1, 3'b011, keep mask for encoder bit 1 (polynomial 1); LSB is pattern position 0.

Ports:
i_clk  in  1  clock.
i_reset  in  1  asynchronous, active-low reset.
i_data  in  2  encoder word; [0] = poly0 bit, [1] = poly1 bit.
i_valid  in  1  i_data valid; accepted only when o_ready=1.
i_last  in  1  qualifies the final word of a frame; meaningful only with i_valid.
i_speed  in  1  0 = bypass (keep all bits), 1 = apply pattern; latched at frame start.
o_ready  out  1  block can accept input this cycle.
o_data  out  2  packed output; [0] = earlier bit in stream order.
o_valid  out  2  per-bit valid: 2'b11 = full pair, 2'b01 = single trailing bit, 2'b00 = idle.
o_last  out  1  marks the final output word of a frame.

Behaviour:
- Reset (i_reset=0, async): o_data=0, o_valid=0, o_last=0, o_ready=1, pattern index=0, hold empty, state=IDLE, latched speed=0.
- FSM states: IDLE, RUN, FLUSH.
- IDLE: on the first accepted word, latch i_speed, process the word at index 0, and go to RUN. If that word also carries i_last, treat it as the end of frame as in RUN.
- RUN: each accepted word advances the pattern index mod p_speed_size. Wrap: the index returns to 0 after p_speed_size-1.
- Keep mask per word: {pol1[idx], pol0[idx]} when the latched speed is 1, else 2'b11.
- Stream order is data[0] before data[1]. Survivors are appended after a 1-bit hold register (h ∈ {0,1}); the survivor count is k ∈ {0,1,2}.
- If h+k ≥ 2: emit the first two bits next cycle with o_valid=2'b11. The remainder (0 or 1 bit) goes to hold. Otherwise nothing is emitted (o_valid=2'b00) and the hold is updated.
- Latency: exactly 1 cycle from accept to the registered output. Outputs are valid for one cycle only; there is no output backpressure.
- End of frame (i_last accepted):
  - If the hold is empty after processing, the emitted word carries o_last=1 and the FSM returns to IDLE.
  - If one bit remains, go to FLUSH with o_ready=0.
  - If no word is emitted on the i_last cycle and the hold is empty (only possible when every bit of the word is deleted), drive a 1-cycle o_last=1 with o_valid=2'b00.
- FLUSH: emit {1'b0, hold} with o_valid=2'b01 and o_last=1, clear the hold, reset the index to 0, and go to IDLE. o_ready returns to 1 the cycle after.
- i_valid while o_ready=0: the word is ignored (not accepted); the upstream source must hold it.
- i_speed changes outside IDLE have no effect until the next frame.
- An all-zero pattern column (both masks 0 at a position) is legal and deletes the whole word.
- Reset asserted mid-frame discards the hold and index immediately; no partial word is emitted.

Optional Feature:
VITERBI_PUNCT_CNT_EN:
- Defined: adds output o_drop_cnt (16 bit), the number of deleted bits since reset. It saturates at 16'hFFFF, clears on reset, and is never cleared by i_last.
- Undefined: the port and the counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared viterbi_pkg: speed encoding constants (SPEED_R12=0, SPEED_PUNCT=1), the FSM state typedef, and the o_valid encodings (VALID_PAIR=2'b11, VALID_SINGLE=2'b01).
- One sub-module, viterbi_punct_pattern: index counter with wrap and frame restart, producing the 2-bit keep mask from the latched speed and parameters.
- Repacking and the FSM stay in the top module.

Test Plan:
- Bypass: speed=0, words 2'b01, 2'b10, 2'b11 with last on the third -> o_data 01, 10, 11, each o_valid=11, 1 cycle later; o_last on the third.
- Rate 3/4: speed=1, words 2'b10, 2'b11, 2'b01 (last on the third) -> outputs 2'b10 (valid 11), then nothing, then 2'b11 (valid 11, o_last=1).
- Flush: speed=1, words 2'b10, 2'b11 with last on the second -> 2'b10 (valid 11), then FLUSH output 2'b01 (valid 01, o_last=1) with o_ready=0 that cycle.
- Wrap: speed=1, 6 words of 2'b11 -> 8 bits = 4 pair outputs; the index returns to 0 at word 4 and the hold is empty at the end.
- Speed latch: toggle i_speed to 1 mid-frame after starting with 0 -> bypass output continues; the next frame after IDLE uses the pattern.
- Reset: assert i_reset low while the hold is full mid-frame -> all outputs are 0 at once; after release, a frame started at index 0 matches the rate 3/4 scenario.
